// File: rtl/cache_mem_arbiter_if.sv
// cache_mem_arbiter_if
//   Bundles the icache/dcache request side and the shared memory port of
//   cache_mem_arbiter.
//   modport master : used by the arbiter (takes requests, drives the memory port)
//   modport slave  : used by the surrounding caches/memory model
//   Parameters: ADDR_W (line address width), LINE_W (cache line width)
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
);
  logic              icache_request;
  logic              dcache_request;
  logic              hit_itlb_in;
  logic              hit_dtlb_in;
  logic [ADDR_W-1:0] itlb_physical_addr_in;
  logic [ADDR_W-1:0] dtlb_physical_addr_in;
  logic              dcache_re;
  logic              dcache_we;
  logic [LINE_W-1:0] dcache_to_mem_data_in;
  logic [LINE_W-1:0] data_from_mem;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] dcache_to_mem_data_out;
  logic              mem_we;
  logic              is_mem_req;
  logic [LINE_W-1:0] mem_to_icache_data;
  logic [LINE_W-1:0] mem_to_dcache_data;
  logic              is_icache_ready;
  logic              is_dcache_ready;
  logic              reset_mem_req;

  modport master (
    input  icache_request, dcache_request, hit_itlb_in, hit_dtlb_in,
           itlb_physical_addr_in, dtlb_physical_addr_in, dcache_re, dcache_we,
           dcache_to_mem_data_in, data_from_mem, mem_ready,
    output mem_addr, dcache_to_mem_data_out, mem_we, is_mem_req,
           mem_to_icache_data, mem_to_dcache_data, is_icache_ready,
           is_dcache_ready, reset_mem_req
  );

  modport slave (
    output icache_request, dcache_request, hit_itlb_in, hit_dtlb_in,
           itlb_physical_addr_in, dtlb_physical_addr_in, dcache_re, dcache_we,
           dcache_to_mem_data_in, data_from_mem, mem_ready,
    input  mem_addr, dcache_to_mem_data_out, mem_we, is_mem_req,
           mem_to_icache_data, mem_to_dcache_data, is_icache_ready,
           is_dcache_ready, reset_mem_req
  );
endinterface

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Single-port arbiter between the icache, the dcache and the shared
//   last-level memory port. One cache is granted at a time; the returned
//   line is captured into a per-cache fill register and a one-cycle
//   ready pulse plus a global reset_mem_req strobe close the transaction.
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous active-low reset
//     bus   : cache_mem_arbiter_if.master (requests, TLB hits, memory port,
//             fill data, ready pulses)
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> ties in IDLE go to the cache not granted last
//     undefined -> dcache has fixed priority
//
// state    | meaning
// ---------+-------------------------------------------------
// S_IDLE   | no grant, waiting for a qualified request
// S_GNT_I  | icache owns the memory port, waiting for mem_ready
// S_GNT_D  | dcache owns the memory port, waiting for mem_ready
// S_DONE_I | icache fill complete: ready pulse + reset_mem_req
// S_DONE_D | dcache access complete: ready pulse + reset_mem_req
module cache_mem_arbiter #(
  parameter int ADDR_W = 20,
  parameter int LINE_W = 128
) (
  input logic                 clk,
  input logic                 reset,
  cache_mem_arbiter_if.master bus
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GNT_I  = 3'd1;
  localparam logic [2:0] S_GNT_D  = 3'd2;
  localparam logic [2:0] S_DONE_I = 3'd3;
  localparam logic [2:0] S_DONE_D = 3'd4;

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic              ireq_v;
  logic              dreq_v;
  logic              pick_d;
  logic [LINE_W-1:0] ifill;
  logic [LINE_W-1:0] dfill;

  assign ireq_v = bus.icache_request & bus.hit_itlb_in;
  assign dreq_v = bus.dcache_request & bus.hit_dtlb_in & (bus.dcache_re | bus.dcache_we);

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant: 0 = icache, 1 = dcache. Starting at icache lets the
  // dcache take the first tie.
  logic last_grant;

  assign pick_d = dreq_v & (~ireq_v | ~last_grant);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b0;
    end else if (state == S_IDLE && (ireq_v || dreq_v)) begin
      last_grant <= pick_d;
    end
  end
`else
  assign pick_d = dreq_v;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (pick_d)      state_nxt = S_GNT_D;
        else if (ireq_v) state_nxt = S_GNT_I;
      end
      // A dropped request wins over a same-cycle mem_ready: the requester
      // has already moved on, so no ready pulse is owed.
      S_GNT_I: begin
        if (!ireq_v)            state_nxt = S_IDLE;
        else if (bus.mem_ready) state_nxt = S_DONE_I;
      end
      S_GNT_D: begin
        if (!dreq_v)            state_nxt = S_IDLE;
        else if (bus.mem_ready) state_nxt = S_DONE_D;
      end
      S_DONE_I: state_nxt = S_IDLE;
      S_DONE_D: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Fill registers load only on a completing grant; a dcache write-back
  // leaves the dcache fill line untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifill <= '0;
      dfill <= '0;
    end else begin
      if (state == S_GNT_I && ireq_v && bus.mem_ready) begin
        ifill <= bus.data_from_mem;
      end
      if (state == S_GNT_D && dreq_v && bus.mem_ready && !bus.dcache_we) begin
        dfill <= bus.data_from_mem;
      end
    end
  end

  always_comb begin
    bus.is_mem_req             = 1'b0;
    bus.mem_addr               = {ADDR_W{1'b0}};
    bus.mem_we                 = 1'b0;
    bus.dcache_to_mem_data_out = {LINE_W{1'b0}};
    bus.is_icache_ready        = 1'b0;
    bus.is_dcache_ready        = 1'b0;
    bus.reset_mem_req          = 1'b0;
    case (state)
      S_GNT_I: begin
        bus.is_mem_req = 1'b1;
        bus.mem_addr   = bus.itlb_physical_addr_in;
      end
      S_GNT_D: begin
        bus.is_mem_req             = 1'b1;
        bus.mem_addr               = bus.dtlb_physical_addr_in;
        bus.mem_we                 = bus.dcache_we;
        bus.dcache_to_mem_data_out = bus.dcache_to_mem_data_in;
      end
      S_DONE_I: begin
        bus.is_icache_ready = 1'b1;
        bus.reset_mem_req   = 1'b1;
      end
      S_DONE_D: begin
        bus.is_dcache_ready = 1'b1;
        bus.reset_mem_req   = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.mem_to_icache_data = ifill;
  assign bus.mem_to_dcache_data = dfill;
endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Directed scoreboard bench for cache_mem_arbiter. Stimulus pushes the
//   expected grant (address / write enable / write data) and the expected
//   completion (which ready, fill lines) into queues; a negedge monitor pops
//   and compares whenever the DUT starts a grant or raises a ready strobe.
//   Honours ARB_ROUND_ROBIN_EN for the tie scenario.
module tb_cache_mem_arbiter;
  localparam int ADDR_W = 20;
  localparam int LINE_W = 128;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic [LINE_W-1:0] wd;
  } gnt_t;

  typedef struct {
    logic              i;
    logic              d;
    logic [LINE_W-1:0] ifill;
    logic [LINE_W-1:0] dfill;
  } done_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  gnt_t  gnt_q[$];
  done_t done_q[$];
  gnt_t  cur;
  done_t de;
  logic  prev_req;
  logic [LINE_W-1:0] exp_ifill;
  logic [LINE_W-1:0] exp_dfill;

  localparam logic [LINE_W-1:0] LINE_A = 128'hDEAD_0001_2222_3333_4444_5555_6666_BEEF;
  localparam logic [LINE_W-1:0] LINE_W1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
  localparam logic [LINE_W-1:0] LINE_X = 128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888;
  localparam logic [LINE_W-1:0] LINE_C = 128'hCAFE_F00D_1357_9BDF_2468_ACE0_1111_2222;
  localparam logic [LINE_W-1:0] LINE_D2 = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_6969_9696;
  localparam logic [LINE_W-1:0] LINE_I2 = 128'h7777_8888_9999_0000_1234_5678_9ABC_DEF0;

  cache_mem_arbiter_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

  cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!bus.is_mem_req && n < 20);
    chk("grant_seen", {127'd0, bus.is_mem_req}, 128'd1);
  endtask

  // Called in GNT: holds mem_ready off for lat-1 cycles, then pulses it
  // with the returned line. Returns just after the edge that enters DONE.
  task automatic finish_gnt(input int lat, input logic [LINE_W-1:0] rdata);
    repeat (lat - 1) tick();
    bus.mem_ready     = 1'b1;
    bus.data_from_mem = rdata;
    tick();
    bus.mem_ready     = 1'b0;
    bus.data_from_mem = '0;
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      prev_req = 1'b0;
    end else begin
      if (bus.is_mem_req && !prev_req) begin
        if (gnt_q.size() == 0) begin
          chk("unexpected_grant", {108'd0, bus.mem_addr}, 128'd0);
          cur = '{addr: bus.mem_addr, we: bus.mem_we, wd: bus.dcache_to_mem_data_out};
        end else begin
          cur = gnt_q.pop_front();
        end
      end
      if (bus.is_mem_req) begin
        chk("mem_addr", {108'd0, bus.mem_addr}, {108'd0, cur.addr});
        chk("mem_we", {127'd0, bus.mem_we}, {127'd0, cur.we});
        chk("mem_wdata", bus.dcache_to_mem_data_out, cur.wd);
      end
      prev_req = bus.is_mem_req;
      if (bus.is_icache_ready || bus.is_dcache_ready || bus.reset_mem_req) begin
        if (done_q.size() == 0) begin
          chk("unexpected_ready", {125'd0, bus.is_icache_ready, bus.is_dcache_ready,
              bus.reset_mem_req}, 128'd0);
        end else begin
          de = done_q.pop_front();
          chk("icache_ready", {127'd0, bus.is_icache_ready}, {127'd0, de.i});
          chk("dcache_ready", {127'd0, bus.is_dcache_ready}, {127'd0, de.d});
          chk("reset_mem_req", {127'd0, bus.reset_mem_req}, 128'd1);
          chk("icache_fill", bus.mem_to_icache_data, de.ifill);
          chk("dcache_fill", bus.mem_to_dcache_data, de.dfill);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset                     = 1'b0;
    bus.icache_request        = 1'b0;
    bus.dcache_request        = 1'b0;
    bus.hit_itlb_in           = 1'b0;
    bus.hit_dtlb_in           = 1'b0;
    bus.itlb_physical_addr_in = '0;
    bus.dtlb_physical_addr_in = '0;
    bus.dcache_re             = 1'b0;
    bus.dcache_we             = 1'b0;
    bus.dcache_to_mem_data_in = '0;
    bus.data_from_mem         = '0;
    bus.mem_ready             = 1'b0;
    exp_ifill                 = '0;
    exp_dfill                 = '0;
    prev_req                  = 1'b0;

    repeat (3) tick();
    chk("rst_is_mem_req", {127'd0, bus.is_mem_req}, 128'd0);
    chk("rst_mem_addr", {108'd0, bus.mem_addr}, 128'd0);
    chk("rst_ready", {125'd0, bus.is_icache_ready, bus.is_dcache_ready, bus.reset_mem_req}, 128'd0);
    chk("rst_ifill", bus.mem_to_icache_data, 128'd0);
    chk("rst_dfill", bus.mem_to_dcache_data, 128'd0);
    reset = 1'b1;
    tick();

    // icache fill, mem_ready after 3 cycles
    bus.itlb_physical_addr_in = 20'h00040;
    bus.hit_itlb_in           = 1'b1;
    bus.icache_request        = 1'b1;
    gnt_q.push_back('{addr: 20'h00040, we: 1'b0, wd: 128'd0});
    exp_ifill = LINE_A;
    done_q.push_back('{i: 1'b1, d: 1'b0, ifill: exp_ifill, dfill: exp_dfill});
    wait_gnt();
    finish_gnt(3, LINE_A);
    bus.icache_request = 1'b0;
    repeat (2) tick();

    // dcache write-back: dcache fill line must not change
    bus.dtlb_physical_addr_in = 20'h01234;
    bus.dcache_to_mem_data_in = LINE_W1;
    bus.hit_dtlb_in           = 1'b1;
    bus.dcache_we             = 1'b1;
    bus.dcache_request        = 1'b1;
    gnt_q.push_back('{addr: 20'h01234, we: 1'b1, wd: LINE_W1});
    done_q.push_back('{i: 1'b0, d: 1'b1, ifill: exp_ifill, dfill: exp_dfill});
    wait_gnt();
    finish_gnt(2, LINE_X);
    bus.dcache_request = 1'b0;
    bus.dcache_we      = 1'b0;
    repeat (2) tick();

    // dcache read, minimum latency
    bus.dtlb_physical_addr_in = 20'h00ABC;
    bus.dcache_re             = 1'b1;
    bus.dcache_request        = 1'b1;
    gnt_q.push_back('{addr: 20'h00ABC, we: 1'b0, wd: LINE_W1});
    exp_dfill = LINE_C;
    done_q.push_back('{i: 1'b0, d: 1'b1, ifill: exp_ifill, dfill: exp_dfill});
    wait_gnt();
    finish_gnt(1, LINE_C);
    bus.dcache_request = 1'b0;
    bus.dcache_re      = 1'b0;
    repeat (2) tick();

    // ITLB miss blocks the icache request
    bus.hit_itlb_in    = 1'b0;
    bus.icache_request = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("tlb_miss_no_req", {127'd0, bus.is_mem_req}, 128'd0);
    end
    bus.icache_request = 1'b0;
    bus.hit_itlb_in    = 1'b1;
    tick();

    // dcache abort, then a stray mem_ready in IDLE
    bus.dtlb_physical_addr_in = 20'h00777;
    bus.dcache_re             = 1'b1;
    bus.dcache_request        = 1'b1;
    gnt_q.push_back('{addr: 20'h00777, we: 1'b0, wd: LINE_W1});
    wait_gnt();
    repeat (2) tick();
    bus.dcache_request = 1'b0;
    tick();
    chk("abort_is_mem_req", {127'd0, bus.is_mem_req}, 128'd0);
    bus.mem_ready     = 1'b1;
    bus.data_from_mem = LINE_X;
    tick();
    bus.mem_ready     = 1'b0;
    bus.data_from_mem = '0;
    bus.dcache_re     = 1'b0;
    tick();
    chk("abort_dfill", bus.mem_to_dcache_data, exp_dfill);
    chk("abort_is_mem_req2", {127'd0, bus.is_mem_req}, 128'd0);

    // async reset in the middle of an icache grant
    bus.itlb_physical_addr_in = 20'h00100;
    bus.icache_request        = 1'b1;
    gnt_q.push_back('{addr: 20'h00100, we: 1'b0, wd: 128'd0});
    wait_gnt();
    tick();
    #2;
    reset = 1'b0;
    #1;
    exp_ifill = '0;
    exp_dfill = '0;
    chk("arst_is_mem_req", {127'd0, bus.is_mem_req}, 128'd0);
    chk("arst_mem_addr", {108'd0, bus.mem_addr}, 128'd0);
    chk("arst_ifill", bus.mem_to_icache_data, exp_ifill);
    chk("arst_dfill", bus.mem_to_dcache_data, exp_dfill);
    bus.icache_request = 1'b0;
    tick();
    reset = 1'b1;
    tick();

    // simultaneous requests straight out of reset: dcache first, then icache
    bus.dtlb_physical_addr_in = 20'h00200;
    bus.itlb_physical_addr_in = 20'h00300;
    bus.dcache_re             = 1'b1;
    bus.dcache_request        = 1'b1;
    bus.icache_request        = 1'b1;
    gnt_q.push_back('{addr: 20'h00200, we: 1'b0, wd: LINE_W1});
    gnt_q.push_back('{addr: 20'h00300, we: 1'b0, wd: 128'd0});
    exp_dfill = LINE_D2;
    done_q.push_back('{i: 1'b0, d: 1'b1, ifill: exp_ifill, dfill: exp_dfill});
    wait_gnt();
    finish_gnt(2, LINE_D2);
`ifndef ARB_ROUND_ROBIN_EN
    bus.dcache_request = 1'b0;
`endif
    exp_ifill = LINE_I2;
    done_q.push_back('{i: 1'b1, d: 1'b0, ifill: exp_ifill, dfill: exp_dfill});
    wait_gnt();
`ifdef ARB_ROUND_ROBIN_EN
    // second tie with both still valid: round robin hands it to the icache
    bus.dcache_request = 1'b0;
`endif
    finish_gnt(2, LINE_I2);
    bus.icache_request = 1'b0;
    bus.dcache_re      = 1'b0;
    repeat (3) tick();

    chk("grants_left", 128'(gnt_q.size()), 128'd0);
    chk("dones_left", 128'(done_q.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Single-port memory arbiter between a core's instruction cache and data cache and the shared last-level memory port.
- Grants one cache at a time and drives the line address, write data and write enable for the granted cache.
- Returns the 128-bit line to the requester and pulses per-cache ready plus a global request-reset strobe.
- Sits inside the core, between both caches and the LLC ports.

Parameters:
- ADDR_W, 20, physical line address width.
- LINE_W, 128, cache line width in bits.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- icache_request  in  1  icache miss/fill request
- dcache_request  in  1  dcache miss/writeback request
- hit_itlb_in  in  1  ITLB hit; qualifies icache_request
- hit_dtlb_in  in  1  DTLB hit; qualifies dcache_request
- itlb_physical_addr_in  in  ADDR_W  icache physical line address
- dtlb_physical_addr_in  in  ADDR_W  dcache physical line address
- dcache_re  in  1  dcache read access in progress
- dcache_we  in  1  dcache write-back to memory
- dcache_to_mem_data_in  in  LINE_W  dcache line to write
- data_from_mem  in  LINE_W  line returned by memory
- mem_ready  in  1  memory completed current request
- mem_addr  out  ADDR_W  address to memory
- dcache_to_mem_data_out  out  LINE_W  write data to memory
- mem_we  out  1  memory write enable
- is_mem_req  out  1  memory request valid
- mem_to_icache_data  out  LINE_W  fill line to icache
- mem_to_dcache_data  out  LINE_W  fill line to dcache
- is_icache_ready  out  1  icache fill complete pulse
- is_dcache_ready  out  1  dcache access complete pulse
- reset_mem_req  out  1  one-cycle strobe: caches drop req

Behaviour:
- Request qualification:
  - ireq_v = icache_request & hit_itlb_in.
  - dreq_v = dcache_request & hit_dtlb_in & (dcache_re | dcache_we).
- FSM states: IDLE, GNT_I, GNT_D, DONE_I, DONE_D.
- Transitions:
  - IDLE: if dreq_v -> GNT_D; else if ireq_v -> GNT_I. The dcache has fixed priority (older instruction).
  - GNT_x: stay until mem_ready=1, then -> DONE_x. On that edge, latch data_from_mem into mem_to_x_data (only on reads for the dcache).
  - DONE_x: lasts one cycle: is_x_ready=1, reset_mem_req=1, then -> IDLE. A new grant can start no earlier than the cycle after DONE.
- Outputs (registered state, combinational decode):
  - is_mem_req=1 only in GNT_I/GNT_D.
  - mem_addr = itlb_physical_addr_in in GNT_I, dtlb_physical_addr_in in GNT_D, else 0.
  - mem_we = dcache_we only in GNT_D, else 0.
  - dcache_to_mem_data_out = dcache_to_mem_data_in in GNT_D, else 0.
- Requester dropping: if the granted request drops (valid deasserts) before mem_ready, abort to IDLE without a ready pulse or reset_mem_req.
- mem_ready outside a GNT state is ignored.
- Fill data registers hold their value until the next fill of the same cache.
- Reset (async, reset=0): state IDLE; all outputs 0; both data registers cleared to 0. Reset mid-grant discards the transaction with no ready pulse.
- Minimum latency: request in IDLE -> is_mem_req next cycle; mem_ready at cycle N -> ready/reset_mem_req at N+1.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined: a 1-bit last_grant register is set on each grant. When both ireq_v and dreq_v are valid in IDLE, the cache not granted last wins. last_grant resets to icache, so the dcache wins the first tie.
- Undefined: fixed dcache priority as above.

Test Plan:
- Icache fill:
  - Stimulus: icache_request=1, hit_itlb_in=1, itlb addr 0x00040; memory returns 0xDEAD..BEEF on mem_ready after 3 cycles.
  - Required: is_mem_req=1, mem_addr=0x00040, mem_we=0; then is_icache_ready and reset_mem_req pulse for 1 cycle; mem_to_icache_data=0xDEAD..BEEF.
- Dcache write-back:
  - Stimulus: dcache_request=1, dcache_we=1, hit_dtlb_in=1, dtlb addr 0x01234, data 0x0123..CDEF.
  - Required: mem_we=1, mem_addr=0x01234, dcache_to_mem_data_out=0x0123..CDEF until mem_ready; is_dcache_ready pulse; mem_to_dcache_data unchanged.
- Simultaneous requests:
  - Stimulus: both valid in the same cycle.
  - Required: dcache is served first, then the icache (the icache request stays held). With ARB_ROUND_ROBIN_EN, two back-to-back ties alternate D, I.
- TLB miss gating:
  - Stimulus: icache_request=1 with hit_itlb_in=0.
  - Required: is_mem_req stays 0 and the FSM stays IDLE.
- Abort:
  - Stimulus: the dcache grant is in progress and dcache_request drops before mem_ready.
  - Required: return to IDLE; no is_dcache_ready or reset_mem_req pulse.
- Async reset:
  - Stimulus: assert reset=0 mid GNT_I.
  - Required: is_mem_req=0, data outputs=0, state IDLE immediately.
